// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage -- MIPS instruction-decode pipeline stage.
//
// Sits between fetch and execute. Drives the register-file read addresses,
// merges returned read data with an optional same-cycle writeback bypass,
// decodes destination/immediate/control fields, detects load-use hazards and
// registers the result into the ID/EX pipeline register.
//
// Build option:
//   DECODE_WB_BYPASS_EN  when defined, a register read that matches the
//                        same-cycle writeback returns wb_wdata instead of
//                        the (pre-write) register-file data.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc     fetched instruction and its PC
//   id_ready                    decode accepts if_instr this cycle
//   stall                       downstream hold, ID/EX keeps contents
//   flush                       redirect, ID/EX becomes a bubble
//   raddr1/raddr2               register-file read addresses (rs/rt)
//   rdata1/rdata2               register-file read data
//   wb_we/wb_waddr/wb_wdata     writeback port (same as reg-file write port)
//   ex_*                        ID/EX pipeline register contents
//   hazard_cnt                  saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic             id_ready,

    input  logic             stall,
    input  logic             flush,

    output logic [4:0]       raddr1,
    output logic [4:0]       raddr2,
    input  logic [31:0]      rdata1,
    input  logic [31:0]      rdata2,

    input  logic             wb_we,
    input  logic [4:0]       wb_waddr,
    input  logic [31:0]      wb_wdata,

    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rs_val,
    output logic [31:0]      ex_rt_val,
    output logic [31:0]      ex_imm,
    output logic [5:0]       ex_opcode,
    output logic [5:0]       ex_funct,
    output logic [4:0]       ex_shamt,
    output logic [4:0]       ex_rd,
    output logic             ex_regwrite,
    output logic             ex_is_load,
    output logic [CNT_W-1:0] hazard_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;

    assign opcode = if_instr[31:26];
    assign rs     = if_instr[25:21];
    assign rt     = if_instr[20:16];
    assign rd     = if_instr[15:11];
    assign shamt  = if_instr[10:6];
    assign funct  = if_instr[5:0];
    assign imm16  = if_instr[15:0];

    assign raddr1 = rs;
    assign raddr2 = rt;

    // ------------------------------------------------------------------
    // Operand selection: register 0 reads as zero, then optional bypass.
    // ------------------------------------------------------------------
    logic        byp1;
    logic        byp2;
    logic [31:0] op1;
    logic [31:0] op2;

`ifdef DECODE_WB_BYPASS_EN
    assign byp1 = wb_we && (wb_waddr == raddr1);
    assign byp2 = wb_we && (wb_waddr == raddr2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    // Writeback port is only consumed by the bypass.
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_waddr};
`endif

    always_comb begin
        op1 = rdata1;
        if (raddr1 == 5'd0) begin
            op1 = 32'd0;
        end else if (byp1) begin
            op1 = wb_wdata;
        end
    end

    always_comb begin
        op2 = rdata2;
        if (raddr2 == 5'd0) begin
            op2 = 32'd0;
        end else if (byp2) begin
            op2 = wb_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [4:0]  dec_rd;
    logic        dec_regwrite;
    logic        dec_is_load;
    logic        dec_zext;
    logic [31:0] dec_imm;
    logic        uses_rt;

    always_comb begin
        if (opcode == OP_RTYPE) begin
            dec_rd = rd;
        end else if (opcode == OP_JAL) begin
            dec_rd = 5'd31;
        end else begin
            dec_rd = rt;
        end
    end

    always_comb begin
        dec_regwrite = 1'b0;
        if (opcode == OP_RTYPE) begin
            dec_regwrite = (funct != FN_JR);
        end else if (opcode == OP_JAL) begin
            dec_regwrite = 1'b1;
        end else if (opcode == OP_LB || opcode == OP_LH || opcode == OP_LW ||
                     opcode == OP_LBU || opcode == OP_LHU) begin
            dec_regwrite = 1'b1;
        end else if (opcode[5:3] == 3'b001) begin
            // ALU-immediate group 0x08..0x0F
            dec_regwrite = 1'b1;
        end
        // Writes to $0 are architecturally discarded.
        if (dec_rd == 5'd0) begin
            dec_regwrite = 1'b0;
        end
    end

    assign dec_is_load = (opcode >= 6'h20) && (opcode <= 6'h25);

    // ANDI/ORI/XORI/LUI (0x0C..0x0F) zero-extend; everything else sign-extends.
    assign dec_zext = (opcode[5:2] == 4'b0011);
    assign dec_imm  = dec_zext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};

    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                     (opcode[5:2] == 4'b1010);

    // ------------------------------------------------------------------
    // Load-use hazard: the load's data is not available until after EX, so
    // a dependent instruction right behind it must wait one cycle.
    // ------------------------------------------------------------------
    logic hazard;

    assign hazard = if_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == raddr1) || (uses_rt && (ex_rd == raddr2)));

    assign id_ready = !stall && !hazard;

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= 32'd0;
            ex_rs_val   <= 32'd0;
            ex_rt_val   <= 32'd0;
            ex_imm      <= 32'd0;
            ex_opcode   <= 6'd0;
            ex_funct    <= 6'd0;
            ex_shamt    <= 5'd0;
            ex_rd       <= 5'd0;
            ex_regwrite <= 1'b0;
            ex_is_load  <= 1'b0;
            hazard_cnt  <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_is_load  <= 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (hazard) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_is_load  <= 1'b0;
            if (hazard_cnt != {CNT_W{1'b1}}) begin
                hazard_cnt <= hazard_cnt + CNT_W'(1);
            end
        end else begin
            // if_valid=0 still loads the decode but marks it as a bubble.
            ex_valid    <= if_valid;
            ex_pc       <= if_pc;
            ex_rs_val   <= op1;
            ex_rt_val   <= op2;
            ex_imm      <= dec_imm;
            ex_opcode   <= opcode;
            ex_funct    <= funct;
            ex_shamt    <= shamt;
            ex_rd       <= dec_rd;
            ex_regwrite <= dec_regwrite && if_valid;
            ex_is_load  <= dec_is_load && if_valid;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        stall;
    logic        flush;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_shamt;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_is_load;
    logic [15:0] hazard_cnt;

    int nvec = 0;
    int nerr = 0;

    decode_stage #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .stall       (stall),
        .flush       (flush),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .wb_we       (wb_we),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs_val   (ex_rs_val),
        .ex_rt_val   (ex_rt_val),
        .ex_imm      (ex_imm),
        .ex_opcode   (ex_opcode),
        .ex_funct    (ex_funct),
        .ex_shamt    (ex_shamt),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .ex_is_load  (ex_is_load),
        .hazard_cnt  (hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change / outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        logic [31:0] exp_byp;

        // Reset with arbitrary inputs
        rst_n    = 1'b0;
        drive(1'b1, 32'h8E090000, 32'hDEAD0000);
        stall    = 1'b0;
        flush    = 1'b0;
        rdata1   = 32'h5555AAAA;
        rdata2   = 32'hAAAA5555;
        wb_we    = 1'b1;
        wb_waddr = 5'd16;
        wb_wdata = 32'h12345678;
        repeat (3) tick();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_rs_val", ex_rs_val, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_is_load", {31'd0, ex_is_load}, 32'd0);
        chk("rst_cnt", {16'd0, hazard_cnt}, 32'd0);
        rst_n = 1'b1;
        wb_we = 1'b0;

        // ADDI $8,$0,5 -- rs=0 must read as 0 despite nonzero rdata1
        drive(1'b1, 32'h20080005, 32'h00000100);
        #1;
        chk("addi_raddr1", {27'd0, raddr1}, 32'd0);
        chk("addi_raddr2", {27'd0, raddr2}, 32'd8);
        chk("addi_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("addi_valid", {31'd0, ex_valid}, 32'd1);
        chk("addi_rd", {27'd0, ex_rd}, 32'd8);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_regwrite", {31'd0, ex_regwrite}, 32'd1);
        chk("addi_rs_val", ex_rs_val, 32'd0);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_opcode", {26'd0, ex_opcode}, 32'h08);

        // Stall for 3 cycles: ID/EX holds, id_ready low
        stall = 1'b1;
        drive(1'b1, 32'h01295020, 32'h00000104);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", {31'd0, id_ready}, 32'd0);
            tick();
            chk("stall_pc", ex_pc, 32'h100);
            chk("stall_rd", {27'd0, ex_rd}, 32'd8);
            chk("stall_valid", {31'd0, ex_valid}, 32'd1);
        end
        stall = 1'b0;

        // if_valid=0 loads a bubble
        drive(1'b0, 32'h20080005, 32'h00000104);
        tick();
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);

        // Bypass: addi $8,$16,0 with stale rdata1 and writeback to $16
        drive(1'b1, 32'h22080000, 32'h00000200);
        rdata1   = 32'd0;
        wb_we    = 1'b1;
        wb_waddr = 5'd16;
        wb_wdata = 32'd1337;
`ifdef DECODE_WB_BYPASS_EN
        exp_byp = 32'd1337;
`else
        exp_byp = 32'd0;
`endif
        tick();
        chk("bypass_rs_val", ex_rs_val, exp_byp);
        wb_we = 1'b0;

        // Immediate extension
        drive(1'b1, 32'h2008FFFF, 32'h00000204);
        tick();
        chk("addi_sext", ex_imm, 32'hFFFFFFFF);
        drive(1'b1, 32'h3408FFFF, 32'h00000208);
        tick();
        chk("ori_zext", ex_imm, 32'h0000FFFF);

        // JAL -> rd 31
        drive(1'b1, 32'h0C000010, 32'h0000020C);
        tick();
        chk("jal_rd", {27'd0, ex_rd}, 32'd31);
        chk("jal_regwrite", {31'd0, ex_regwrite}, 32'd1);

        // SW: no regwrite, not a load
        drive(1'b1, 32'hAE090000, 32'h00000210);
        tick();
        chk("sw_regwrite", {31'd0, ex_regwrite}, 32'd0);
        chk("sw_is_load", {31'd0, ex_is_load}, 32'd0);

        // Write to $0 suppressed
        drive(1'b1, 32'h20000005, 32'h00000214);
        tick();
        chk("r0_regwrite", {31'd0, ex_regwrite}, 32'd0);

        // JR $31: no regwrite
        drive(1'b1, 32'h03E00008, 32'h00000218);
        tick();
        chk("jr_regwrite", {31'd0, ex_regwrite}, 32'd0);

        // Load-use: lw $9,0($16) ; add $10,$9,$9
        drive(1'b1, 32'h8E090000, 32'h00000300);
        tick();
        chk("lw_is_load", {31'd0, ex_is_load}, 32'd1);
        chk("lw_rd", {27'd0, ex_rd}, 32'd9);
        drive(1'b1, 32'h01295020, 32'h00000304);
        #1;
        chk("lu_ready", {31'd0, id_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_cnt", {16'd0, hazard_cnt}, 32'd1);
        chk("lu_ready_after", {31'd0, id_ready}, 32'd1);
        rdata1   = 32'h0000ABCD;
        rdata2   = 32'h0000ABCD;
        wb_we    = 1'b1;
        wb_waddr = 5'd9;
        wb_wdata = 32'h0000ABCD;
        tick();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rd", {27'd0, ex_rd}, 32'd10);
        chk("lu_add_rs_val", ex_rs_val, 32'h0000ABCD);
        chk("lu_add_funct", {26'd0, ex_funct}, 32'h20);
        chk("lu_cnt_hold", {16'd0, hazard_cnt}, 32'd1);
        wb_we = 1'b0;

        // Flush during load-use cycle: flush wins, count unchanged
        drive(1'b1, 32'h8E090000, 32'h00000400);
        tick();
        drive(1'b1, 32'h01295020, 32'h00000404);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_cnt", {16'd0, hazard_cnt}, 32'd1);
        tick();
        chk("flush_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("flush_add_pc", ex_pc, 32'h404);

        // lw $9 then addi $9,$0,1: rt matches but addi does not read rt
        drive(1'b1, 32'h8E090000, 32'h00000500);
        tick();
        drive(1'b1, 32'h20090001, 32'h00000504);
        #1;
        chk("nort_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("nort_valid", {31'd0, ex_valid}, 32'd1);
        chk("nort_cnt", {16'd0, hazard_cnt}, 32'd1);

        // Stall + hazard: hold, count unchanged; then hazard counts
        drive(1'b1, 32'h8E090000, 32'h00000600);
        tick();
        drive(1'b1, 32'h01295020, 32'h00000604);
        stall = 1'b1;
        tick();
        chk("sh_valid", {31'd0, ex_valid}, 32'd1);
        chk("sh_is_load", {31'd0, ex_is_load}, 32'd1);
        chk("sh_cnt", {16'd0, hazard_cnt}, 32'd1);
        stall = 1'b0;
        tick();
        chk("sh_cnt_after", {16'd0, hazard_cnt}, 32'd2);
        chk("sh_bubble", {31'd0, ex_valid}, 32'd0);

        // Asynchronous reset mid-stall
        drive(1'b1, 32'h20080005, 32'h00000700);
        tick();
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_cnt", {16'd0, hazard_cnt}, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_imm", ex_imm, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage of the MIPS core. It sits between fetch and execute and is the sole driver of the register file read ports. It takes the fetched instruction, presents `raddr1`/`raddr2` to the register file, and merges the returned `rdata1`/`rdata2` with a same-cycle writeback bypass. It decodes destination, immediate and control fields, detects load-use hazards, and registers everything into the ID/EX pipeline register.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating hazard-bubble counter

Ports:
- `clk`  in  1  rising-edge clock, shared with the register file
- `rst_n`  in  1  asynchronous, active-low reset
- `if_valid`  in  1  `if_instr`/`if_pc` hold a valid instruction
- `if_instr`  in  32  fetched instruction
- `if_pc`  in  32  PC of `if_instr`
- `id_ready`  out  1  decode accepts `if_instr` this cycle
- `stall`  in  1  downstream hold; ID/EX keeps its contents
- `flush`  in  1  branch/jump redirect; ID/EX becomes a bubble
- `raddr1`, `raddr2`  out  5  register-file read addresses
- `rdata1`, `rdata2`  in  32  register-file read data
- `wb_we`, `wb_waddr[4:0]`, `wb_wdata[31:0]`  in  —  writeback port, the same signals that drive the register-file write port
- `ex_valid`  out  1  ID/EX holds a real instruction
- `ex_pc`  out  32  PC of the instruction in ID/EX
- `ex_rs_val`, `ex_rt_val`  out  32  operand values
- `ex_imm`  out  32  extended immediate
- `ex_opcode[5:0]`, `ex_funct[5:0]`, `ex_shamt[4:0]`, `ex_rd[4:0]`  out  —  decoded fields; `ex_rd` is the destination register
- `ex_regwrite`, `ex_is_load`  out  1  control bits
- `hazard_cnt`  out  `CNT_W`  count of load-use bubbles inserted

## Operation
- Read addresses are combinational: `raddr1 = if_instr[25:21]` (rs), `raddr2 = if_instr[20:16]` (rt).
- Operand selection, per port:
  - If the address is 0, the value is 0.
  - Otherwise, if bypass applies (see Configuration) and `wb_we && wb_waddr==raddrN`, the value is `wb_wdata`.
  - Otherwise the value is `rdataN`.
- Destination register:
  - opcode 0x00 → rd (`[15:11]`)
  - JAL (0x03) → 31
  - other writers → rt
- `ex_regwrite` is 1 for:
  - R-type, except JR (funct 0x08)
  - JAL
  - loads 0x20, 0x21, 0x23, 0x24, 0x25
  - 0x08–0x0F

  It is 0 for stores, branches and J, and it is forced to 0 when the destination is 0.
- `ex_is_load` is 1 for opcodes 0x20–0x25.
- Immediate: opcodes 0x0C, 0x0D, 0x0E and 0x0F are zero-extended; all others are sign-extended.
- `uses_rt` is 1 for R-type, BEQ (0x04), BNE (0x05) and stores (0x28–0x2B).
- Load-use hazard: `hazard = if_valid && ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==raddr1 || (uses_rt && ex_rd==raddr2))`.
- `id_ready = !stall && !hazard`. Fetch must hold `if_instr`/`if_pc` while `id_ready` is 0.
- ID/EX update priority at each rising edge:
  1. `flush`: set `ex_valid`=0 and `ex_regwrite`=0; other fields don't-care.
  2. `stall`: hold all ID/EX contents.
  3. `hazard`: insert a bubble (`ex_valid`=0, `ex_regwrite`=0); `hazard_cnt` +1, saturating at all-ones.
  4. Otherwise load the decoded instruction, with `ex_valid = if_valid`.
- When `if_valid`=0, a bubble is loaded and the read addresses are still driven from `if_instr`.

## Timing
- `raddr*`, `hazard` and `id_ready` are combinational from `if_instr`, ID/EX state and `stall`.
- Decode-to-ID/EX latency is 1 cycle.
- A load followed immediately by a dependent instruction costs exactly 1 bubble. On the next cycle `ex_is_load` is 0, so the instruction proceeds; the load data is then taken from the writeback bypass or the register file.
- Reset (asynchronous, any cycle, including mid-stall): every `ex_*` output = 0, `ex_valid` = 0, `hazard_cnt` = 0.
- `flush` and `hazard` in the same cycle: flush wins and `hazard_cnt` is unchanged.
- `stall` and `hazard` in the same cycle: hold and `hazard_cnt` is unchanged.

## Configuration
- `DECODE_WB_BYPASS_EN`
  - Defined: the writeback bypass described under Operation is active.
  - Undefined: operands come only from `rdataN` (0 for register 0). A read that matches a same-cycle writeback returns the pre-write value, and software must schedule around it.

## Test plan
- Reset: hold `rst_n`=0 with arbitrary inputs, then release → all `ex_*` = 0, `ex_valid` = 0, `hazard_cnt` = 0.
- Decode ADDI: `if_instr`=0x20080005 (addi $8,$0,5), `if_pc`=0x100 → next edge: `ex_rd`=8, `ex_imm`=5, `ex_regwrite`=1, `ex_rs_val`=0, `ex_pc`=0x100.
- Bypass: with `DECODE_WB_BYPASS_EN` defined, `wb_we`=1, `wb_waddr`=16, `wb_wdata`=1337, and an instruction with rs=16 while `rdata1` holds stale 0 → `ex_rs_val`=1337. With the macro undefined → `ex_rs_val`=0.
- Load-use:
  - Stimulus: 0x8E090000 (lw $9,0($16)) followed by 0x01295020 (add $10,$9,$9).
  - Cycle after lw: `id_ready`=0 for 1 cycle and one bubble is inserted; `hazard_cnt`=1.
  - Next cycle: the add enters ID/EX with `ex_rd`=10.
- Flush vs hazard: assert `flush` during the load-use cycle → `ex_valid`=0 and `hazard_cnt` unchanged.
- Stall hold: `stall`=1 for 3 cycles after ADDI → ID/EX unchanged and `id_ready`=0 throughout.
